// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared types and constants for the program loader.
//   - LOADER_ADDR_W / LOADER_DATA_W : RAM address and byte widths
//   - loader_state_t                : loader FSM state encoding
//   - frame_field_t                 : position of a byte within a load frame
//   - csum_ok()                     : checksum acceptance test
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing CSUM byte).
// -----------------------------------------------------------------------------
package program_loader_pkg;

  localparam int LOADER_ADDR_W = 8;
  localparam int LOADER_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } loader_state_t;

  // Frame layout: BASE, LEN (0 encodes 256), LEN data bytes, optional CSUM.
  typedef enum logic [1:0] {
    FLD_BASE = 2'd0,
    FLD_LEN  = 2'd1,
    FLD_DATA = 2'd2,
    FLD_CSUM = 2'd3
  } frame_field_t;

  // A frame is good when the data bytes plus the checksum byte sum to zero mod 256.
  function automatic logic csum_ok(input logic [LOADER_DATA_W-1:0] sum,
                                   input logic [LOADER_DATA_W-1:0] csum);
    logic [LOADER_DATA_W-1:0] total;
    total = sum + csum;
    return (total == {LOADER_DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// -----------------------------------------------------------------------------
// program_loader_if
// Byte stream handshake feeding the program loader.
//   data  : stream byte
//   valid : data valid (driven by the source)
//   ready : sink accepts a byte this cycle
// Modports: master = byte source (host/UART/testbench), slave = loader.
// -----------------------------------------------------------------------------
interface program_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Fills the CPU program/data RAM from a byte stream and keeps the CPU halted
// until the load finishes.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   i_start      : one-cycle pulse, begins a load session (from IDLE/DONE/ERR)
//   s_in         : byte stream (program_loader_if.slave)
//   o_mem_addr   : RAM write address   o_mem_wdata : RAM write data
//   o_mem_we     : RAM write strobe, one cycle per accepted data byte
//   o_cpu_run    : CPU release (1 only in DONE)
//   o_busy       : session in progress
//   o_done       : load finished (sticky until next start)
//   o_err        : checksum mismatch (sticky); constant 0 without checksum
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN adds the CSUM byte,
// the running-sum accumulator and the ERR path.
// -----------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  program_loader_if.slave   s_in,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_cpu_run,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_run;
  logic              w_accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              r_err;
`endif

  assign w_accept = s_in.valid & r_ready;

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = ST_ADDR;
        else         w_next = r_state;
      end
      ST_ADDR: begin
        if (w_accept) w_next = ST_LEN;
        else          w_next = r_state;
      end
      ST_LEN: begin
        if (w_accept) w_next = ST_DATA;
        else          w_next = r_state;
      end
      ST_DATA: begin
        if (w_accept && (r_cnt == {DATA_W{1'b0}})) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_next = ST_CSUM;
`else
          w_next = ST_DONE;
`endif
        end else begin
          w_next = r_state;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (w_accept) w_next = csum_ok(r_sum, s_in.data) ? ST_DONE : ST_ERR;
        else          w_next = r_state;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (i_start) w_next = ST_ADDR;
        else         w_next = r_state;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register, datapath (pointer, counter, sum) and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= {ADDR_W{1'b0}};
      r_cnt       <= {DATA_W{1'b0}};
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_mem_we    <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_run       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_sum       <= {DATA_W{1'b0}};
      r_err       <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_mem_we <= 1'b0;
      // ready/busy track the state being entered so no byte is taken in DONE/ERR.
      r_ready  <= (w_next == ST_ADDR) || (w_next == ST_LEN) ||
                  (w_next == ST_DATA) || (w_next == ST_CSUM);
      r_busy   <= (w_next == ST_ADDR) || (w_next == ST_LEN) ||
                  (w_next == ST_DATA) || (w_next == ST_CSUM);
      // Coming straight from DATA, hold release back one cycle so the last
      // write lands before the CPU can fetch.
      r_done   <= (w_next == ST_DONE) && (r_state != ST_DATA);
      r_run    <= (w_next == ST_DONE) && (r_state != ST_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_err    <= (w_next == ST_ERR);
`endif
      case (r_state)
        ST_ADDR: begin
          if (w_accept) r_ptr <= ADDR_W'(s_in.data);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          r_sum <= {DATA_W{1'b0}};
`endif
        end
        ST_LEN: begin
          // LEN = 0 wraps to 255 here, giving a 256-byte frame.
          if (w_accept) r_cnt <= s_in.data - DATA_W'(1);
        end
        ST_DATA: begin
          if (w_accept) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= s_in.data;
            r_ptr       <= r_ptr + ADDR_W'(1);
            r_cnt       <= r_cnt - DATA_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum       <= r_sum + s_in.data;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_in.ready  = r_ready;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_cpu_run   = r_run;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign o_err       = r_err;
`else
  assign o_err       = 1'b0;
`endif

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream writer that fills the CPU's 256×8 unified program/data RAM before execution and holds the CPU halted until the load completes. It drives the RAM write port (address, write data, write enable) that the CPU otherwise only reads during fetch. It releases the CPU through `cpu_run`. Input bytes arrive over a valid/ready handshake from a host-side source such as a UART receiver or a testbench.

## Interface
Parameters:
- `ADDR_W`, 8, RAM address width; RAM depth is 2^ADDR_W.
- `DATA_W`, 8, byte width.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low (`clk`, `rst_n`).
- `clk`  in  1  system clock, shared with the CPU and RAM.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a load session.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_addr`  out  8  RAM write address.
- `mem_wdata`  out  8  RAM write data.
- `mem_we`  out  1  RAM write strobe, one cycle per byte.
- `cpu_run`  out  1  CPU clock-enable / release; 0 = CPU held.
- `busy`  out  1  session in progress.
- `done`  out  1  load finished successfully; sticky.
- `err`  out  1  checksum mismatch; sticky. Only driven when checksum is compiled in; otherwise tied to 0.

## Operation
- A byte is accepted on a rising edge where `in_valid & in_ready` is high. `in_data` may change freely when the byte is not accepted.
- Frame format: BASE (start address), LEN (byte count; 0 means 256), then LEN data bytes, then CSUM if enabled.
- FSM states: IDLE, ADDR, LEN, DATA, CSUM (macro only), DONE, ERR.
  - IDLE → ADDR on `start`.
  - ADDR → LEN on accept; latch `ptr` = BASE.
  - LEN → DATA on accept; latch `cnt` = LEN − 1, 8-bit wrap, so LEN = 0 gives 255, i.e. 256 bytes.
  - DATA: on each accept, issue a write at `ptr`, then `ptr` += 1 (mod 256) and `cnt` −= 1. When the accepted byte arrives with `cnt` = 0, go to CSUM if enabled, else DONE.
  - CSUM → DONE if (sum of data bytes + CSUM) mod 256 = 0, else ERR.
  - DONE / ERR → ADDR on `start`. This clears `done`, `err` and `cpu_run` and begins a new session.
- `start` while in ADDR, LEN, DATA or CSUM is ignored.
- `in_ready` = 1 exactly in ADDR, LEN, DATA and CSUM.
- `busy` = 1 in every state except IDLE, DONE and ERR.
- `cpu_run` = 1 only in DONE. In ERR the CPU stays held.
- Address pointer wraps from 0xFF to 0x00 with no error.

## Timing
- Reset values: state IDLE. `in_ready`, `mem_we`, `cpu_run`, `busy`, `done`, `err` = 0. `mem_addr`, `mem_wdata` = 0x00. `ptr`, `cnt` and the checksum accumulator = 0.
- Write latency: a data byte accepted at edge *t* produces `mem_we` = 1 with the matching `mem_addr`/`mem_wdata` for the cycle after edge *t*. Write outputs are registered.
- `mem_we` is never high for two consecutive cycles unless two bytes were accepted on consecutive edges.
- Full throughput: one byte per cycle while `in_valid` is held high.
- Without checksum: the state is DONE the cycle after the last data byte is accepted. `done` and `cpu_run` become visible one cycle after the last `mem_we`, so the CPU never fetches before the final write lands.
- With checksum: `done`/`err` assert the cycle after CSUM is accepted.
- Reset mid-session: on the first edge with `rst_n` = 0, all outputs return to their reset values, including deasserting `mem_we` and `cpu_run`. The partially written RAM contents are left as they are.

## Configuration
- Macro `PROGRAM_LOADER_CHECKSUM_EN`.
- Defined: the CSUM state, the 8-bit running-sum accumulator (cleared in ADDR) and the ERR path are present.
- Undefined: DATA goes directly to DONE; ERR is unreachable; `err` is tied to 0; no CSUM byte is expected in the frame.

## Structure
- Shared package `program_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - `LOADER_ADDR_W` = 8 and `LOADER_DATA_W` = 8;
  - the frame-field encodings.
- No sub-module: the FSM, counter, pointer and accumulator are one flat block.
- Integration at CPU top level:
  - RAM write-port mux selects loader vs CPU by `cpu_run`;
  - `cpu_run` gates the phase counter and the CPU register enables.

## Test plan
- Basic load: start; BASE = 0x00, LEN = 6, bytes E0 04 E4 02 24 00 with `in_valid` held high → six `mem_we` pulses at addresses 0–5 on consecutive cycles. `cpu_run` goes to 1 one cycle after the last write; RAM[0..5] match the input bytes.
- Wrap and LEN = 0: BASE = 0xFE, LEN = 0, 256 bytes → writes go to 0xFE, 0xFF, 0x00, … 0xFD; exactly 256 strobes, then `done`.
- Back-pressure: toggle `in_valid` randomly during DATA → each write appears one cycle after its accept; no duplicated or dropped bytes; `start` pulses mid-session are ignored.
- Checksum (macro defined): data 01 02 03 with CSUM 0xFA → `done` = 1, `cpu_run` = 1. Repeat with CSUM 0xFB → `err` = 1, `cpu_run` = 0.
- Reset mid-DATA: drive `rst_n` low after the 3rd of 6 bytes → the next cycle shows all outputs at reset values and state IDLE. A fresh `start` then completes a new session normally.
- Restart from DONE: `start` pulse while in DONE → `cpu_run` drops the next cycle and `in_ready` = 1 (state ADDR).
